step_timer_ctrl: RTL

//   Control stage placed directly upstream of the saturating step counter.
//   On a start request it clears the counter, then issues one-cycle enable

---
 rtl/step_timer_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/step_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : step_timer_ctrl
// Purpose  : Clears a downstream step counter, then paces its enable at a
//            fixed prescaled rate until the counter reports done.
// Revision : 1.0
// ============================================================================
module step_timer_ctrl #(
    parameter int DIV   = 4,
    parameter int DIV_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic pause,
    input  logic abort,
    input  logic cnt_done,
    output logic cnt_rst,
    output logic cnt_en,
    output logic busy,
    output logic finished
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_RUN    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] c_presc_max = DIV_W'(DIV - 1);

    state_t           r_state;
    logic [DIV_W-1:0] r_presc;
    logic             r_start_q;
    logic             r_cnt_rst;
    logic             r_busy;
    logic             r_finished;

    logic w_start_edge;
    logic w_tick;

    assign w_start_edge = start & ~r_start_q;
    assign w_tick       = (r_presc == c_presc_max);

    // Step enable must react in the same cycle as abort/done/pause, so it is
    // decoded combinationally rather than registered.
    assign cnt_en   = (r_state == S_RUN) & w_tick & ~abort & ~cnt_done & ~pause;
    assign cnt_rst  = r_cnt_rst;
    assign busy     = r_busy;
    assign finished = r_finished;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_start_q  <= 1'b0;
            r_cnt_rst  <= 1'b0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            r_start_q  <= start;
            r_cnt_rst  <= 1'b0;
            r_finished <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_start_edge) begin
                        r_state   <= S_CLEAR;
                        r_cnt_rst <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_presc <= '0;
                    r_busy  <= 1'b1;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    // An abort leaves the counter value untouched on purpose.
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_presc <= '0;
                        r_busy  <= 1'b0;
                    end else if (cnt_done) begin
                        r_state    <= S_FINISH;
                        r_finished <= 1'b1;
                        r_busy     <= 1'b0;
                    end else if (!pause) begin
                        r_presc <= w_tick ? '0 : r_presc + 1'b1;
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
